// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared action encoding, priority-mode constants and default
//               widths for the pipeline-stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ACT_RESET = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_LOAD  = 2'd3
    } action_e;

    localparam int PRIO_STALL = 0;
    localparam int PRIO_FLUSH = 1;

    // Defaults shared by the IF/ID, ID/EX, EX/MEM and MEM/WB instances
    localparam int DEF_CTRL_W = 16;
    localparam int DEF_DATA_W = 160;
    localparam int DEF_CNT_W  = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_max = {W{1'b1}};
    localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Clear wins over increment; the counter sticks at its maximum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline-stage register with stall/flush control
//               and saturating stall, flush and bubble event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W           = DEF_CTRL_W,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int FLUSH_OVER_STALL = PRIO_STALL,
    parameter int FLUSH_ZERO_DATA  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cnt_clr,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    action_e             w_action;
    logic                w_stall_ev;
    logic                w_flush_ev;
    logic                w_bubble_ev;

    logic                r_valid;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_data;

    always_comb begin
        w_action = ACT_LOAD;
        if (!rst_n) begin
            w_action = ACT_RESET;
        end else if (FLUSH_OVER_STALL == PRIO_FLUSH) begin
            if (flush) begin
                w_action = ACT_FLUSH;
            end else if (stall) begin
                w_action = ACT_HOLD;
            end
        end else begin
            if (stall) begin
                w_action = ACT_HOLD;
            end else if (flush) begin
                w_action = ACT_FLUSH;
            end
        end
    end

    // Flush never loads data_in: upstream data may be stale during a load-use stall
    always_ff @(posedge clk) begin
        case (w_action)
            ACT_RESET: begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_data  <= '0;
            end
            ACT_FLUSH: begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                if (FLUSH_ZERO_DATA != 0) begin
                    r_data <= '0;
                end
            end
            ACT_LOAD: begin
                r_valid <= valid_in;
                r_ctrl  <= valid_in ? ctrl_in : '0;
                r_data  <= data_in;
            end
            default: begin
            end
        endcase
    end

    assign valid_out = r_valid;
    assign ctrl_out  = r_ctrl;
    assign data_out  = r_data;

    assign w_stall_ev  = (w_action == ACT_HOLD);
    assign w_flush_ev  = (w_action == ACT_FLUSH);
    assign w_bubble_ev = (w_action == ACT_FLUSH) || ((w_action == ACT_LOAD) && !valid_in);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_stall_ev),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_flush_ev),
        .cnt   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_bubble_ev),
        .cnt   (bubble_cnt)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed bench driving two pipe_stage_reg configurations
//               (stall-priority/hold-data and flush-priority/zero-data, 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 160;

    localparam logic [DW-1:0] c_p = 160'h0123456789ABCDEF_FEDCBA9876543210_CAFEBABE;
    localparam logic [DW-1:0] c_q = 160'h5A5A5A5A_11223344_55667788_99AABBCC_DDEEFF00;
    localparam logic [DW-1:0] c_r = 160'hF0F0F0F0_0F0F0F0F_13579BDF_2468ACE0_AAAA5555;

    typedef struct {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [15:0]   sc;
        logic [15:0]   fc;
        logic [15:0]   bc;
    } out_t;

    typedef struct {
        logic          rst_n;
        logic          stall;
        logic          flush;
        logic          valid;
        logic          clr;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        out_t          ea;
        out_t          eb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, valid_in, cnt_clr;
    logic [CW-1:0] ctrl_in;
    logic [DW-1:0] data_in;

    logic          a_valid, b_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [15:0]   a_sc, a_fc, a_bc;
    logic [3:0]    b_sc, b_fc, b_bc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CNT_W(16),
        .FLUSH_OVER_STALL(0), .FLUSH_ZERO_DATA(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
        .valid_out(a_valid), .ctrl_out(a_ctrl), .data_out(a_data),
        .stall_cnt(a_sc), .flush_cnt(a_fc), .bubble_cnt(a_bc)
    );

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CNT_W(4),
        .FLUSH_OVER_STALL(1), .FLUSH_ZERO_DATA(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
        .valid_out(b_valid), .ctrl_out(b_ctrl), .data_out(b_data),
        .stall_cnt(b_sc), .flush_cnt(b_fc), .bubble_cnt(b_bc)
    );

    function automatic out_t mko(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input logic [15:0] sc, input logic [15:0] fc, input logic [15:0] bc);
        out_t o;
        o.v = v; o.c = c; o.d = d; o.sc = sc; o.fc = fc; o.bc = bc;
        return o;
    endfunction

    function automatic vec_t mkv(input logic r, input logic s, input logic f, input logic v,
                                 input logic clr, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input out_t ea, input out_t eb);
        vec_t x;
        x.rst_n = r; x.stall = s; x.flush = f; x.valid = v; x.clr = clr;
        x.ctrl = c; x.data = d; x.ea = ea; x.eb = eb;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t e, input logic v, input logic [CW-1:0] c,
                             input logic [DW-1:0] d, input logic [15:0] sc, input logic [15:0] fc,
                             input logic [15:0] bc);
        cmp({tag, ".valid"}, DW'(v), DW'(e.v));
        cmp({tag, ".ctrl"}, DW'(c), DW'(e.c));
        cmp({tag, ".data"}, d, e.d);
        cmp({tag, ".stall_cnt"}, DW'(sc), DW'(e.sc));
        cmp({tag, ".flush_cnt"}, DW'(fc), DW'(e.fc));
        cmp({tag, ".bubble_cnt"}, DW'(bc), DW'(e.bc));
        cmp({tag, ".ctrl_when_invalid"}, DW'(!v && (c != '0)), '0);
    endtask

    task automatic check_both(input string tag, input out_t ea, input out_t eb);
        check_out({tag, " A"}, ea, a_valid, a_ctrl, a_data, a_sc, a_fc, a_bc);
        check_out({tag, " B"}, eb, b_valid, b_ctrl, b_data, {12'b0, b_sc}, {12'b0, b_fc}, {12'b0, b_bc});
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v, input logic clr,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
        rst_n = r; stall = s; flush = f; valid_in = v; cnt_clr = clr; ctrl_in = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[$];
        out_t z;
        z = mko(1'b0, '0, '0, 16'd0, 16'd0, 16'd0);

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        cnt_clr = 1'b0; ctrl_in = '0; data_in = '0;

        //                 rst  stl  fl   vld  clr   ctrl      data
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000, '0,  z, z));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b1,1'b0, 16'hA5A5, c_p, z, z));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0, 16'hA5A5, c_p,
                           mko(1, 16'hA5A5, c_p, 0, 0, 0), mko(1, 16'hA5A5, c_p, 0, 0, 0)));
        vecs.push_back(mkv(1'b1,1'b0,1'b1,1'b1,1'b0, 16'h1234, '0,
                           mko(0, 16'h0000, c_p, 0, 1, 1), mko(0, 16'h0000, '0, 0, 1, 1)));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0, 16'h1111, c_q,
                           mko(1, 16'h1111, c_q, 0, 1, 1), mko(1, 16'h1111, c_q, 0, 1, 1)));
        vecs.push_back(mkv(1'b1,1'b1,1'b1,1'b1,1'b0, 16'h2222, c_r,
                           mko(1, 16'h1111, c_q, 1, 1, 1), mko(0, 16'h0000, '0, 0, 2, 2)));
        vecs.push_back(mkv(1'b1,1'b1,1'b1,1'b1,1'b0, 16'h2222, c_r,
                           mko(1, 16'h1111, c_q, 2, 1, 1), mko(0, 16'h0000, '0, 0, 3, 3)));
        vecs.push_back(mkv(1'b1,1'b1,1'b1,1'b1,1'b0, 16'h2222, c_r,
                           mko(1, 16'h1111, c_q, 3, 1, 1), mko(0, 16'h0000, '0, 0, 4, 4)));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0, 16'hFFFF, c_r,
                           mko(0, 16'h0000, c_r, 3, 1, 2), mko(0, 16'h0000, c_r, 0, 4, 5)));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0, 16'h3333, c_q,
                           mko(1, 16'h3333, c_q, 3, 1, 2), mko(1, 16'h3333, c_q, 0, 4, 5)));
        vecs.push_back(mkv(1'b1,1'b1,1'b0,1'b0,1'b0, 16'hFFFF, '0,
                           mko(1, 16'h3333, c_q, 4, 1, 2), mko(1, 16'h3333, c_q, 1, 4, 5)));
        vecs.push_back(mkv(1'b1,1'b1,1'b0,1'b0,1'b1, 16'hFFFF, '0,
                           mko(1, 16'h3333, c_q, 0, 0, 0), mko(1, 16'h3333, c_q, 0, 0, 0)));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b1, 16'h4444, c_p,
                           mko(1, 16'h4444, c_p, 0, 0, 0), mko(1, 16'h4444, c_p, 0, 0, 0)));
        vecs.push_back(mkv(1'b1,1'b0,1'b1,1'b0,1'b0, 16'h0000, c_q,
                           mko(0, 16'h0000, c_p, 0, 1, 1), mko(0, 16'h0000, '0, 0, 1, 1)));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].valid,
                  vecs[i].clr, vecs[i].ctrl, vecs[i].data);
            check_both($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb);
        end

        // Saturation: A keeps counting, B (4-bit) sticks at 15 with outputs frozen
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, c_q);
        check_both("sat_load", mko(1, 16'h5555, c_q, 0, 1, 1), mko(1, 16'h5555, c_q, 0, 1, 1));
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, c_r);
            check_both($sformatf("sat_stall%0d", i),
                       mko(1, 16'h5555, c_q, 16'(i), 1, 1),
                       mko(1, 16'h5555, c_q, (i > 15) ? 16'd15 : 16'(i), 1, 1));
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, c_r);
        check_both("sat_clr", mko(1, 16'h5555, c_q, 0, 0, 0), mko(1, 16'h5555, c_q, 0, 0, 0));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, c_r);
        check_both("sat_after_clr", mko(1, 16'h5555, c_q, 1, 0, 0), mko(1, 16'h5555, c_q, 1, 0, 0));

        // Reset in the middle of stall/flush activity
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, c_p);
        check_both("pre_rst", mko(1, 16'h5555, c_q, 2, 0, 0), mko(0, 16'h0000, '0, 1, 1, 1));
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7777, c_p);
        check_both("mid_rst", z, z);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h6666, c_r);
        check_both("post_rst_load", mko(1, 16'h6666, c_r, 0, 0, 0), mko(1, 16'h6666, c_r, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
